// File: rtl/hme_ip_rx_pkg.sv
// Shared constants, state encoding and ring helpers
// for the RX frame writer.
package hme_ip_rx_pkg;

   localparam int DEPTH           = 768;
   localparam int AW              = 10;
   localparam int MAX_FRAME_BYTES = 1536;
   localparam int LEN_W           = 12;

   localparam int HDR_LEN_MSB   = 15;
   localparam int HDR_LEN_LSB   = 0;
   localparam int HDR_VALID_BIT = 31;

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      DATA,
      HDR,
      DROP
   } state_e;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] x);
      return (x == AW'(DEPTH - 1)) ? '0 : x + AW'(1);
   endfunction

   function automatic logic [31:0] hdr_word(input logic [LEN_W-1:0] len);
      logic [31:0] w;
      w = '0;
      w[HDR_VALID_BIT] = 1'b1;
      w[HDR_LEN_MSB:HDR_LEN_LSB] = 16'(len);
      return w;
   endfunction

endpackage

// File: rtl/hme_ip_rx_byte_packer.sv
// Four-lane little-endian byte accumulator; presents the
// completed (or last, zero-padded) word combinationally.
module hme_ip_rx_byte_packer
   import hme_ip_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   input  logic        in_take,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        word_valid,
   output logic [31:0] word_data
);

   logic [1:0]  lane_q, lane_d;
   logic [23:0] acc_q, acc_d;

   always_comb begin
      unique case (lane_q)
         2'd0:    word_data = {24'h0, in_data};
         2'd1:    word_data = {16'h0, in_data, acc_q[7:0]};
         2'd2:    word_data = {8'h0, in_data, acc_q[15:0]};
         default: word_data = {in_data, acc_q};
      endcase
      word_valid = in_valid && ((lane_q == 2'd3) || in_last);
   end

   always_comb begin
      lane_d = lane_q;
      acc_d  = acc_q;
      if (clr || (in_take && word_valid)) begin
         lane_d = '0;
         acc_d  = '0;
      end else if (in_take) begin
         lane_d = lane_q + 2'd1;
         acc_d  = word_data[23:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q <= '0;
         acc_q  <= '0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/hme_ip_rx_frame_writer.sv
// Packs RX bytes into the circular RX RAM and commits a
// header word only after a good end-of-frame.
module hme_ip_rx_frame_writer
   import hme_ip_rx_pkg::*;
(
   input  logic          clkw,
   input  logic          rstw,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          rx_last,
   input  logic          rx_err,
   input  logic [AW-1:0] rd_ptr,
   output logic          cew,
   output logic [AW-1:0] aw,
   output logic [31:0]   dw,
   output logic [AW-1:0] wr_ptr,
   output logic          frame_done,
   output logic          drop_err,
   output logic          drop_ovf
);

   state_e state_q, state_d;

   logic [AW-1:0]    fstart_q, fstart_d;
   logic [AW-1:0]    cur_q, cur_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    aw_q, aw_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [31:0]      dw_q, dw_d;
   logic             cew_q, cew_d;
   logic             done_q, done_d;
   logic             derr_q, derr_d;
   logic             dovf_q, dovf_d;
   logic             ovf_q, ovf_d;

   logic             take;
   logic [AW-1:0]    wcur;
   logic [LEN_W-1:0] len_nxt;
   logic             pk_take;
   logic             pk_clr;
   logic             pk_word_valid;
   logic [31:0]      pk_word;

   hme_ip_rx_byte_packer u_packer (
      .clk        (clkw),
      .rst        (rstw),
      .clr        (pk_clr),
      .in_valid   (rx_valid),
      .in_take    (pk_take),
      .in_data    (rx_data),
      .in_last    (rx_last),
      .word_valid (pk_word_valid),
      .word_data  (pk_word)
   );

   always_comb begin
      state_d  = state_q;
      fstart_d = fstart_q;
      cur_d    = cur_q;
      len_d    = len_q;
      wr_ptr_d = wr_ptr_q;
      aw_d     = aw_q;
      dw_d     = dw_q;
      cew_d    = 1'b0;
      done_d   = 1'b0;
      derr_d   = 1'b0;
      dovf_d   = 1'b0;
      ovf_d    = ovf_q;
      pk_take  = 1'b0;
      take     = 1'b0;
      wcur     = cur_q;
      len_nxt  = len_q + LEN_W'(1);

      unique case (state_q)
         SYNC: begin
            if (!rx_valid) state_d = IDLE;
         end
         IDLE: begin
            if (rx_valid) begin
               fstart_d = wr_ptr_q;
               wcur     = inc(wr_ptr_q);
               cur_d    = wcur;
               len_nxt  = LEN_W'(1);
               // no room even for the header slot
               if (inc(wr_ptr_q) == rd_ptr) begin
                  ovf_d = 1'b1;
                  if (rx_last) dovf_d = 1'b1;
                  else         state_d = DROP;
               end else begin
                  take = 1'b1;
               end
            end
         end
         DATA: begin
            if (rx_valid) take = 1'b1;
         end
         HDR: begin
            cew_d    = 1'b1;
            aw_d     = fstart_q;
            dw_d     = hdr_word(len_q);
            wr_ptr_d = cur_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         DROP: begin
            if (rx_valid && rx_last) begin
               dovf_d  = ovf_q;
               derr_d  = !ovf_q;
               state_d = IDLE;
            end
         end
         default: state_d = SYNC;
      endcase

      if (take) begin
         len_d = len_nxt;
         if (len_nxt > LEN_W'(MAX_FRAME_BYTES)) begin
            ovf_d = 1'b0;
            if (rx_last) begin
               derr_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end else if (pk_word_valid && (inc(wcur) == rd_ptr)) begin
            ovf_d = 1'b1;
            if (rx_last) begin
               dovf_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end else begin
            pk_take = 1'b1;
            state_d = DATA;
            if (pk_word_valid) begin
               cew_d = 1'b1;
               aw_d  = wcur;
               dw_d  = pk_word;
               cur_d = inc(wcur);
            end
            if (rx_last) begin
               if (rx_err) begin
                  derr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = HDR;
               end
            end
         end
      end
   end

   // any exit from DATA discards a partially packed word
   assign pk_clr = (state_d != DATA);

   always_ff @(posedge clkw) begin
      if (rstw) begin
         state_q  <= SYNC;
         fstart_q <= '0;
         cur_q    <= '0;
         len_q    <= '0;
         wr_ptr_q <= '0;
         aw_q     <= '0;
         dw_q     <= '0;
         cew_q    <= 1'b0;
         done_q   <= 1'b0;
         derr_q   <= 1'b0;
         dovf_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fstart_q <= fstart_d;
         cur_q    <= cur_d;
         len_q    <= len_d;
         wr_ptr_q <= wr_ptr_d;
         aw_q     <= aw_d;
         dw_q     <= dw_d;
         cew_q    <= cew_d;
         done_q   <= done_d;
         derr_q   <= derr_d;
         dovf_q   <= dovf_d;
         ovf_q    <= ovf_d;
      end
   end

   assign cew        = cew_q;
   assign aw         = aw_q;
   assign dw         = dw_q;
   assign wr_ptr     = wr_ptr_q;
   assign frame_done = done_q;
   assign drop_err   = derr_q;
   assign drop_ovf   = dovf_q;

endmodule

// File: tb/tb_hme_ip_rx_frame_writer.sv
// Scoreboard bench for the RX frame writer: expected RAM
// writes and frame events are queued, a monitor pops them.
module tb_hme_ip_rx_frame_writer;

   localparam int AW = 10;

   logic          clkw = 1'b0;
   logic          rstw;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_last;
   logic          rx_err;
   logic [AW-1:0] rd_ptr;
   logic          cew;
   logic [AW-1:0] aw;
   logic [31:0]   dw;
   logic [AW-1:0] wr_ptr;
   logic          frame_done;
   logic          drop_err;
   logic          drop_ovf;

   hme_ip_rx_frame_writer dut (
      .clkw       (clkw),
      .rstw       (rstw),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_last    (rx_last),
      .rx_err     (rx_err),
      .rd_ptr     (rd_ptr),
      .cew        (cew),
      .aw         (aw),
      .dw         (dw),
      .wr_ptr     (wr_ptr),
      .frame_done (frame_done),
      .drop_err   (drop_err),
      .drop_ovf   (drop_ovf)
   );

   always #5 clkw = ~clkw;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   typedef struct packed {
      logic [2:0]    k;
      logic [AW-1:0] wp;
   } ev_t;

   localparam logic [2:0] EV_DONE = 3'b100;
   localparam logic [2:0] EV_ERR  = 3'b010;
   localparam logic [2:0] EV_OVF  = 3'b001;

   wr_t exp_wr[$];
   ev_t exp_ev[$];
   wr_t mon_w;
   ev_t mon_e;
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
      exp_wr.push_back('{a: a, d: d});
   endtask

   task automatic push_ev(input logic [2:0] k, input logic [AW-1:0] wp);
      exp_ev.push_back('{k: k, wp: wp});
   endtask

   function automatic logic [31:0] pat_word(input logic [7:0] first,
                                            input logic [7:0] step,
                                            input int n, input int w);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 4; j++)
         if (4 * w + j < n) r[8*j +: 8] = 8'(first + step * (4 * w + j));
      return r;
   endfunction

   task automatic push_pat_words(input logic [7:0] first,
                                 input logic [7:0] step,
                                 input int n, input int words,
                                 input int base);
      for (int w = 0; w < words; w++)
         push_wr(AW'((base + w) % 768), pat_word(first, step, n, w));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clkw); #1;
         rx_valid = 1'b0;
         rx_last  = 1'b0;
         rx_err   = 1'b0;
      end
   endtask

   task automatic send_pat(input logic [7:0] first, input logic [7:0] step,
                           input int n, input logic err);
      for (int i = 0; i < n; i++) begin
         @(posedge clkw); #1;
         rx_valid = 1'b1;
         rx_data  = 8'(first + step * i);
         rx_last  = (i == n - 1);
         rx_err   = err && (i == n - 1);
      end
      idle(3);
   endtask

   always @(negedge clkw) begin
      if (mon_en) begin
         if (cew) begin
            if (exp_wr.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_write: aw=%0d dw=%08h, none expected",
                        aw, dw);
            end else begin
               mon_w = exp_wr.pop_front();
               check("wr_addr", 64'(aw), 64'(mon_w.a));
               check("wr_data", 64'(dw), 64'(mon_w.d));
            end
         end
         if (frame_done || drop_err || drop_ovf) begin
            if (exp_ev.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_event: done/err/ovf=%b, none expected",
                        {frame_done, drop_err, drop_ovf});
            end else begin
               mon_e = exp_ev.pop_front();
               check("event_kind", 64'({frame_done, drop_err, drop_ovf}),
                     64'(mon_e.k));
               check("event_wr_ptr", 64'(wr_ptr), 64'(mon_e.wp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rstw     = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rx_last  = 1'b0;
      rx_err   = 1'b0;
      rd_ptr   = '0;
      repeat (3) @(posedge clkw);
      @(negedge clkw);
      check("rst_cew", 64'(cew), 64'(0));
      check("rst_aw", 64'(aw), 64'(0));
      check("rst_dw", 64'(dw), 64'(0));
      check("rst_wr_ptr", 64'(wr_ptr), 64'(0));
      check("rst_pulses", 64'({frame_done, drop_err, drop_ovf}), 64'(0));
      @(posedge clkw); #1;
      rstw   = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // 4-byte good frame
      push_wr(10'd1, 32'h44332211);
      push_wr(10'd0, 32'h80000004);
      push_ev(EV_DONE, 10'd2);
      send_pat(8'h11, 8'h11, 4, 1'b0);

      // 5-byte frame, partial last word
      push_wr(10'd3, 32'h44332211);
      push_wr(10'd4, 32'h00000055);
      push_wr(10'd2, 32'h80000005);
      push_ev(EV_DONE, 10'd5);
      send_pat(8'h11, 8'h11, 5, 1'b0);

      // errored frame, then reuse of the same fstart
      push_wr(10'd6, 32'h04030201);
      push_wr(10'd7, 32'h08070605);
      push_ev(EV_ERR, 10'd5);
      send_pat(8'h01, 8'h01, 8, 1'b1);
      push_wr(10'd6, 32'h0000A2A1);
      push_wr(10'd5, 32'h80000002);
      push_ev(EV_DONE, 10'd7);
      send_pat(8'hA1, 8'h01, 2, 1'b0);

      // ring fills mid-frame
      rd_ptr = 10'd10;
      push_wr(10'd8, 32'h04030201);
      push_ev(EV_OVF, 10'd7);
      send_pat(8'h01, 8'h01, 12, 1'b0);

      // ring full at frame start
      rd_ptr = 10'd8;
      push_ev(EV_OVF, 10'd7);
      send_pat(8'h01, 8'h01, 4, 1'b0);

      // single-byte frame
      rd_ptr = 10'd0;
      push_wr(10'd8, 32'h0000005A);
      push_wr(10'd7, 32'h80000001);
      push_ev(EV_DONE, 10'd9);
      send_pat(8'h5A, 8'h00, 1, 1'b0);

      // reset in the middle of a frame
      push_wr(10'd10, 32'hC4C3C2C1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clkw); #1;
         rx_valid = 1'b1;
         rx_data  = 8'(8'hC1 + i);
         rx_last  = 1'b0;
      end
      @(posedge clkw); #1;
      rx_data = 8'hC7;
      rstw    = 1'b1;
      @(posedge clkw); #1;
      rstw    = 1'b0;
      rx_data = 8'hC8;
      repeat (2) begin
         @(posedge clkw); #1;
         rx_data = rx_data + 8'h01;
      end
      idle(3);
      @(negedge clkw);
      check("mid_rst_wr_ptr", 64'(wr_ptr), 64'(0));
      push_wr(10'd1, 32'hDDCCBBAA);
      push_wr(10'd0, 32'h80000004);
      push_ev(EV_DONE, 10'd2);
      send_pat(8'hAA, 8'h11, 4, 1'b0);

      // oversize frame is dropped as an error
      push_pat_words(8'h00, 8'h01, 1537, 384, 3);
      push_ev(EV_ERR, 10'd2);
      send_pat(8'h00, 8'h01, 1537, 1'b0);

      // maximum-length frame is accepted
      push_pat_words(8'h00, 8'h01, 1536, 384, 3);
      push_wr(10'd2, 32'h80000600);
      push_ev(EV_DONE, 10'd387);
      send_pat(8'h00, 8'h01, 1536, 1'b0);

      // fill up to wr_ptr 766
      push_pat_words(8'h00, 8'h01, 1512, 378, 388);
      push_wr(10'd387, 32'h800005E8);
      push_ev(EV_DONE, 10'd766);
      send_pat(8'h00, 8'h01, 1512, 1'b0);

      // data wraps past the end of the ring
      rd_ptr = 10'd10;
      push_wr(10'd767, 32'h04030201);
      push_wr(10'd0, 32'h08070605);
      push_wr(10'd766, 32'h80000008);
      push_ev(EV_DONE, 10'd1);
      send_pat(8'h01, 8'h01, 8, 1'b0);

      for (int i = 0; i < 20; i++) begin
         if (exp_wr.size() == 0 && exp_ev.size() == 0) break;
         @(negedge clkw);
      end
      check("writes_outstanding", 64'(exp_wr.size()), 64'(0));
      check("events_outstanding", 64'(exp_ev.size()), 64'(0));
      @(negedge clkw);
      check("final_wr_ptr", 64'(wr_ptr), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hme_ip_rx_frame_writer.md
Name: hme_ip_rx_frame_writer

Overview:
Upstream write-side stage of the ethernet_mac RX path. It packs the byte stream from the RX MAC into 32-bit words and writes them into the 768x32 RX dual-port RAM through its cew/aw/dw write port, which it treats as a circular buffer. Each frame is preceded by a one-word header that is written only after a good end-of-frame. Errored, oversize or overflowing frames are rolled back without ever being committed, so the AHB-side reader only ever sees complete good frames.

Parameters:
DEPTH, 768, number of RAM words in the ring.
AW, 10, RAM address width.
MAX_FRAME_BYTES, 1536, longest frame accepted; a longer frame is dropped as an error.

Ports:
clkw  in  1  write-side clock, shared with the RAM write port.
rstw  in  1  reset, synchronous, active-high.
rx_valid  in  1  rx_data holds a valid byte this cycle.
rx_data  in  8  frame byte, first byte first.
rx_last  in  1  qualifies the final byte of a frame.
rx_err  in  1  sampled with rx_last; 1 marks a bad frame (CRC, PHY error).
rd_ptr  in  AW  next word the consumer will read, already in clkw domain.
cew  out  1  RAM write enable.
aw  out  AW  RAM write address.
dw  out  32  RAM write data.
wr_ptr  out  AW  committed write pointer, one past the last committed frame.
frame_done  out  1  1-cycle pulse when a frame is committed.
drop_err  out  1  1-cycle pulse when a frame is dropped for rx_err or oversize.
drop_ovf  out  1  1-cycle pulse when a frame is dropped because the ring is full.

Behaviour:
- Reset: cew=0, aw=0, dw=0, wr_ptr=0, all pulses 0. The state machine enters SYNC.
- Ring arithmetic: inc(x) = (x==DEPTH-1) ? 0 : x+1. A write to address a is legal only when inc(a) != rd_ptr, which leaves one guard word between writer and reader.
- All outputs are registered. A RAM write appears one cycle after the byte that completes its word.
- SYNC: discards input. Moves to IDLE on the first cycle with rx_valid=0, so reset in the middle of a frame never yields a partial frame.
- IDLE: on rx_valid:
  - Record fstart=wr_ptr and set cur=inc(wr_ptr).
  - If inc(wr_ptr)==rd_ptr, go to DROP with the overflow flag set.
  - Otherwise place the byte in lane 0 and go to DATA.
  - The single-byte-frame case (rx_last in this cycle) is handled as in DATA.
- DATA:
  - Each valid byte goes into lane = len[1:0], little-endian: first byte is bits 7:0.
  - The 12-bit len counter increments per byte.
  - When lane 3 is filled or rx_last is seen, the word is written at cur and cur advances. Unused lanes of a partial word are 0.
  - Before each write, if inc(cur)==rd_ptr, the word is not written; go to DROP with the overflow flag set.
  - If len exceeds MAX_FRAME_BYTES, go to DROP with the error flag set.
  - On rx_last: if rx_err=1, pulse drop_err and go to IDLE. Otherwise go to HDR.
- HDR: one cycle.
  - cew=1, aw=fstart, dw={1'b1, 15'b0, len[15:0]}; bit 31 is the valid marker.
  - Registered at the end of that cycle: wr_ptr<=cur and frame_done=1. Both are visible in the following cycle, after the last data write.
- DROP: discards bytes until rx_last. Then pulses drop_ovf or drop_err, whichever flag is set (overflow wins), and returns to IDLE. wr_ptr is never changed.
- The source guarantees at least 2 idle cycles after rx_last (interframe gap). rx_valid during HDR is ignored.
- rd_ptr may advance at any time. The full check always uses the current rd_ptr.
- Reset in any state: outputs return to reset values in the next cycle. Frames in flight are lost and wr_ptr returns to 0. The consumer is reset together with this block.

Decomposition:
- Package hme_ip_rx_pkg holds:
  - DEPTH, AW, MAX_FRAME_BYTES.
  - Header field positions: LEN 15:0, VALID bit 31.
  - State enum: SYNC, IDLE, DATA, HDR, DROP.
  - The ring inc() function.
- One sub-module, hme_ip_rx_byte_packer: 4-lane byte accumulator with lane counter, word_valid output and partial-word flush on last.

Test Plan:
- wr_ptr=0, rd_ptr=0, 4-byte frame 11 22 33 44 -> write aw=1 dw=0x44332211; write aw=0 dw=0x80000004; wr_ptr=2; frame_done once.
- 5-byte frame 11..55 from wr_ptr=0 -> aw=1 0x44332211; aw=2 0x00000055; header aw=0 0x80000005; wr_ptr=3.
- 8-byte frame with rx_err=1 on last -> data writes occur, no header write, wr_ptr unchanged, drop_err pulse. Next frame starts at the same fstart.
- Wrap: wr_ptr=766, rd_ptr=10, 8-byte frame -> data at 767 and 0, header at 766, wr_ptr=1.
- Overflow: wr_ptr=0, rd_ptr=3, 12-byte frame -> writes at 1 only, the write at 2 is suppressed, then drop_ovf at rx_last and wr_ptr stays 0. With rd_ptr=1 at frame start there are no writes at all and drop_ovf pulses.
- Assert rstw mid-frame with rx_valid still high -> no writes until rx_valid goes low. The next frame is written with header at 0 and data from 1.
- Oversize: 1537-byte good frame -> drop_err, no header write, wr_ptr unchanged.
